// File: rtl/pc_mux.sv
// Fetch-stage PC source selector and registered instruction-fetch address.
// Selects boot, EPC, trap vector or sequential/branch target, and flags misaligned jump targets.
module pc_mux #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [1:0]  pc_src_in,
    input  logic [31:0] epc_in,
    input  logic [31:0] trap_address_in,
    input  logic        branch_taken_in,
    input  logic [31:0] iaddr_in,
    input  logic        ahb_ready_in,
    input  logic [31:0] pc_in,
    output logic [31:0] iaddr_out,
    output logic [31:0] pc_plus_4_out,
    output logic [31:0] pc_mux_out,
    output logic        misaligned_instr_logic_out
);

    logic [31:0] w_pc_plus_4;
    logic [31:0] w_next_pc;
    logic [31:0] w_pc_mux;
    logic [31:0] r_iaddr;

    assign w_pc_plus_4 = pc_in + 32'd4;

    // Bit 0 of a jump target is always dropped so JALR targets land on halfword boundaries.
    assign w_next_pc = branch_taken_in ? {iaddr_in[31:1], 1'b0} : w_pc_plus_4;

    always_comb begin
        w_pc_mux = BOOT_ADDRESS;
        case (pc_src_in)
            2'b00:   w_pc_mux = BOOT_ADDRESS;
            2'b01:   w_pc_mux = epc_in;
            2'b10:   w_pc_mux = trap_address_in;
            default: w_pc_mux = w_next_pc;
        endcase
    end

    // Holding on ahb_ready_in low stalls fetch; skipped selections are simply dropped.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_iaddr <= BOOT_ADDRESS;
        end else if (ahb_ready_in) begin
            r_iaddr <= w_pc_mux;
        end
    end

    assign iaddr_out                  = r_iaddr;
    assign pc_plus_4_out              = w_pc_plus_4;
    assign pc_mux_out                 = w_pc_mux;
    assign misaligned_instr_logic_out = branch_taken_in & w_next_pc[1];

endmodule

// File: tb/tb_pc_mux.sv
// Self-checking bench for pc_mux: directed cases followed by randomized traffic
// compared against an arithmetic reference model of the PC selection rules.
module tb_pc_mux;

    localparam logic [31:0] BOOT = 32'h0000_0000;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [1:0]  pc_src_in;
    logic [31:0] epc_in;
    logic [31:0] trap_address_in;
    logic        branch_taken_in;
    logic [31:0] iaddr_in;
    logic        ahb_ready_in;
    logic [31:0] pc_in;
    logic [31:0] iaddr_out;
    logic [31:0] pc_plus_4_out;
    logic [31:0] pc_mux_out;
    logic        misaligned_instr_logic_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_iaddr;

    pc_mux #(.BOOT_ADDRESS(BOOT)) dut (
        .clk_in                     (clk_in),
        .rst_in                     (rst_in),
        .pc_src_in                  (pc_src_in),
        .epc_in                     (epc_in),
        .trap_address_in            (trap_address_in),
        .branch_taken_in            (branch_taken_in),
        .iaddr_in                   (iaddr_in),
        .ahb_ready_in               (ahb_ready_in),
        .pc_in                      (pc_in),
        .iaddr_out                  (iaddr_out),
        .pc_plus_4_out              (pc_plus_4_out),
        .pc_mux_out                 (pc_mux_out),
        .misaligned_instr_logic_out (misaligned_instr_logic_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_pc4(input logic [31:0] pc);
        longint unsigned s;
        s = (longint'(pc) + 4) % 64'h1_0000_0000;
        return s[31:0];
    endfunction

    function automatic logic [31:0] model_target(input logic [31:0] tgt);
        return (tgt / 2) * 2;
    endfunction

    function automatic logic model_misaligned();
        return branch_taken_in && (model_target(iaddr_in) % 4 != 0);
    endfunction

    function automatic logic [31:0] model_mux();
        logic [31:0] sources [4];
        sources[0] = BOOT;
        sources[1] = epc_in;
        sources[2] = trap_address_in;
        sources[3] = branch_taken_in ? model_target(iaddr_in) : model_pc4(pc_in);
        return sources[pc_src_in];
    endfunction

    task automatic check_comb(input string tag);
        check({tag, ".pc4"}, pc_plus_4_out, model_pc4(pc_in));
        check({tag, ".mux"}, pc_mux_out, model_mux());
        check({tag, ".mis"}, {31'd0, misaligned_instr_logic_out}, {31'd0, model_misaligned()});
    endtask

    // Advance one clock edge, updating the register model from pre-edge inputs.
    task automatic tick(input string tag);
        logic [31:0] nxt;
        nxt = exp_iaddr;
        if (rst_in) nxt = BOOT;
        else if (ahb_ready_in) nxt = model_mux();
        @(posedge clk_in);
        #1;
        exp_iaddr = nxt;
        check({tag, ".iaddr"}, iaddr_out, exp_iaddr);
    endtask

    initial begin
        rst_in = 1'b1; pc_src_in = 2'b00; epc_in = '0; trap_address_in = '0;
        branch_taken_in = 1'b0; iaddr_in = '0; ahb_ready_in = 1'b0; pc_in = '0;
        exp_iaddr = BOOT;
        #3;
        check("reset_iaddr", iaddr_out, BOOT);
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        // Boot select
        pc_src_in = 2'b00; pc_in = 32'h1234_5678; #1;
        check("boot_mux", pc_mux_out, 32'h0000_0000);
        check("boot_pc4", pc_plus_4_out, 32'h1234_567C);
        check("boot_mis", {31'd0, misaligned_instr_logic_out}, 32'd0);

        // EPC / trap select, trap wins over taken branch
        pc_src_in = 2'b01; epc_in = 32'hACBE_FC5D; #1;
        check("epc_mux", pc_mux_out, 32'hACBE_FC5D);
        pc_src_in = 2'b10; trap_address_in = 32'h1122_3344;
        branch_taken_in = 1'b1; iaddr_in = 32'h5678_9ABC; #1;
        check("trap_mux", pc_mux_out, 32'h1122_3344);
        check("trap_mis", {31'd0, misaligned_instr_logic_out}, 32'd0);
        // Non-operating source still reports a misaligned target
        iaddr_in = 32'h5678_9ABE; #1;
        check("trap_mis_hi", {31'd0, misaligned_instr_logic_out}, 32'd1);

        // Operating mode
        pc_src_in = 2'b11; branch_taken_in = 1'b0; pc_in = 32'h1234_5678; #1;
        check("seq_mux", pc_mux_out, 32'h1234_567C);
        branch_taken_in = 1'b1; iaddr_in = 32'h5678_9ABD; #1;
        check("br_mux", pc_mux_out, 32'h5678_9ABC);
        check("br_mis", {31'd0, misaligned_instr_logic_out}, 32'd0);
        iaddr_in = 32'h5678_9ABE; #1;
        check("br_mux2", pc_mux_out, 32'h5678_9ABE);
        check("br_mis2", {31'd0, misaligned_instr_logic_out}, 32'd1);

        // Register load then 3-edge stall
        branch_taken_in = 1'b0; pc_in = 32'h1234_5678; ahb_ready_in = 1'b1;
        tick("load");
        check("load_val", iaddr_out, 32'h1234_567C);
        ahb_ready_in = 1'b0; pc_in = 32'h0000_1000;
        for (int i = 0; i < 3; i++) tick("stall");
        check("stall_val", iaddr_out, 32'h1234_567C);

        // Async reset between edges, held regardless of ready
        #2; rst_in = 1'b1; #1;
        exp_iaddr = BOOT;
        check("arst_now", iaddr_out, 32'h0000_0000);
        ahb_ready_in = 1'b1; tick("arst_rdy1");
        ahb_ready_in = 1'b0; tick("arst_rdy0");
        rst_in = 1'b0; ahb_ready_in = 1'b1; pc_src_in = 2'b01; epc_in = 32'hDEAD_BEE0;
        tick("post_rst");
        check("post_rst_val", iaddr_out, 32'hDEAD_BEE0);

        // Wrap-around
        pc_in = 32'hFFFF_FFFC; #1;
        check("wrap_pc4", pc_plus_4_out, 32'h0000_0000);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            pc_src_in       = 2'($urandom_range(0, 3));
            epc_in          = $urandom;
            trap_address_in = $urandom;
            branch_taken_in = 1'($urandom_range(0, 1));
            iaddr_in        = $urandom;
            ahb_ready_in    = ($urandom_range(0, 3) != 0);
            pc_in           = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
            rst_in          = ($urandom_range(0, 19) == 0);
            #1;
            if (rst_in) begin
                exp_iaddr = BOOT;
                check("rnd_arst", iaddr_out, exp_iaddr);
            end
            check_comb("rnd");
            tick("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
